// File: rtl/systolic_pe_ws_if.sv
// Port bundle for one weight-stationary systolic PE; the master side drives the PE inputs.
interface systolic_pe_ws_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic              clear;
  logic [DATA_W-1:0] act_in;
  logic              act_valid_in;
  logic [DATA_W-1:0] act_out;
  logic              act_valid_out;
  logic [ACC_W-1:0]  psum_in;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_valid_out;
  logic [DATA_W-1:0] w_in;
  logic              w_load;
  logic [DATA_W-1:0] w_out;
  logic              w_swap;
  logic              ovf;

  modport master (
    output clear, act_in, act_valid_in, psum_in, w_in, w_load, w_swap,
    input  act_out, act_valid_out, psum_out, psum_valid_out, w_out, ovf
  );

  modport slave (
    input  clear, act_in, act_valid_in, psum_in, w_in, w_load, w_swap,
    output act_out, act_valid_out, psum_out, psum_valid_out, w_out, ovf
  );
endinterface

// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic PE: psum_out = psum_in + act_in * active weight, double-buffered
// shadow weight. Define PE_SATURATE_EN for saturating accumulation with a sticky ovf flag.
module systolic_pe_ws #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input logic             clk,
  input logic             rst,
  systolic_pe_ws_if.slave bus
);
  if (ACC_W < 2 * DATA_W) begin : g_width_check
    $error("systolic_pe_ws: ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic {StEmpty, StLoaded} state_e;

  state_e                     r_state, w_state_next;
  logic signed [DATA_W-1:0]   r_active;
  logic signed [DATA_W-1:0]   r_shadow;
  logic                       r_shadow_vld;
  logic [DATA_W-1:0]          r_act;
  logic                       r_act_vld;
  logic [ACC_W-1:0]           r_psum;
  logic                       r_psum_vld;
  logic                       r_ovf;

  logic                       w_do_swap;
  logic signed [DATA_W-1:0]   w_act_s;
  logic signed [ACC_W-1:0]    w_psum_s;
  logic signed [2*DATA_W-1:0] w_mul;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_clamp;

  // A swap only commits when the shadow actually holds a freshly loaded weight.
  assign w_do_swap = bus.w_swap & r_shadow_vld;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty:  if (w_do_swap) w_state_next = StLoaded;
      StLoaded: w_state_next = StLoaded;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else begin
      if (w_do_swap) r_active <= r_shadow;
      if (bus.w_load) begin
        r_shadow     <= bus.w_in;
        r_shadow_vld <= 1'b1;
      end else if (w_do_swap) begin
        r_shadow_vld <= 1'b0;
      end
    end
  end

  assign w_act_s  = bus.act_in;
  assign w_psum_s = bus.psum_in;
  assign w_mul    = w_act_s * r_active;
  assign w_prod   = (r_state == StLoaded) ? w_mul : '0;

`ifdef PE_SATURATE_EN
  logic signed [ACC_W:0] w_sum_wide;

  assign w_sum_wide = (ACC_W+1)'(w_psum_s) + (ACC_W+1)'(w_prod);
  // Top two bits disagree exactly when the ACC_W-bit result would have wrapped.
  assign w_clamp    = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];

  always_comb begin
    w_sum = w_sum_wide[ACC_W-1:0];
    if (w_clamp) begin
      w_sum = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign w_sum   = w_psum_s + ACC_W'(w_prod);
  assign w_clamp = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act      <= '0;
      r_act_vld  <= 1'b0;
      r_psum     <= '0;
      r_psum_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.clear) begin
      r_act      <= '0;
      r_act_vld  <= 1'b0;
      r_psum     <= '0;
      r_psum_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_act      <= bus.act_in;
      r_act_vld  <= bus.act_valid_in;
      r_psum_vld <= bus.act_valid_in;
      if (bus.act_valid_in) begin
        r_psum <= w_sum;
        if (w_clamp) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.act_out        = r_act;
  assign bus.act_valid_out  = r_act_vld;
  assign bus.psum_out       = r_psum;
  assign bus.psum_valid_out = r_psum_vld;
  assign bus.w_out          = r_shadow;
  assign bus.ovf            = r_ovf;
endmodule

// File: tb/tb_systolic_pe_ws.sv
// Self-checking bench for systolic_pe_ws: directed scenarios plus a randomized run against a
// behavioural model. Honours PE_SATURATE_EN the same way as the design.
module tb_systolic_pe_ws;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  systolic_pe_ws_if #(.DATA_W(DW), .ACC_W(AW)) m_if ();
  systolic_pe_ws #(.DATA_W(DW), .ACC_W(AW)) u_dut (.clk(clk), .rst(rst), .bus(m_if));

  // Four-deep column used for the weight chain and the 32-bit overflow case.
  systolic_pe_ws_if #(.DATA_W(DW), .ACC_W(CW)) c0_if ();
  systolic_pe_ws_if #(.DATA_W(DW), .ACC_W(CW)) c1_if ();
  systolic_pe_ws_if #(.DATA_W(DW), .ACC_W(CW)) c2_if ();
  systolic_pe_ws_if #(.DATA_W(DW), .ACC_W(CW)) c3_if ();
  systolic_pe_ws #(.DATA_W(DW), .ACC_W(CW)) u_c0 (.clk(clk), .rst(rst), .bus(c0_if));
  systolic_pe_ws #(.DATA_W(DW), .ACC_W(CW)) u_c1 (.clk(clk), .rst(rst), .bus(c1_if));
  systolic_pe_ws #(.DATA_W(DW), .ACC_W(CW)) u_c2 (.clk(clk), .rst(rst), .bus(c2_if));
  systolic_pe_ws #(.DATA_W(DW), .ACC_W(CW)) u_c3 (.clk(clk), .rst(rst), .bus(c3_if));

  assign c1_if.w_in   = c0_if.w_out;
  assign c2_if.w_in   = c1_if.w_out;
  assign c3_if.w_in   = c2_if.w_out;
  assign c1_if.w_load = c0_if.w_load;
  assign c2_if.w_load = c0_if.w_load;
  assign c3_if.w_load = c0_if.w_load;
  assign c1_if.w_swap = c0_if.w_swap;
  assign c2_if.w_swap = c0_if.w_swap;
  assign c3_if.w_swap = c0_if.w_swap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sx(longint v, int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic drv_m(input logic clr, input logic [DW-1:0] a, input logic av,
                       input logic [AW-1:0] p, input logic [DW-1:0] w, input logic ld,
                       input logic sw);
    m_if.clear = clr; m_if.act_in = a; m_if.act_valid_in = av; m_if.psum_in = p;
    m_if.w_in = w; m_if.w_load = ld; m_if.w_swap = sw;
  endtask

  task automatic drv_c0(input logic clr, input logic [DW-1:0] a, input logic av,
                        input logic [CW-1:0] p, input logic [DW-1:0] w, input logic ld,
                        input logic sw);
    c0_if.clear = clr; c0_if.act_in = a; c0_if.act_valid_in = av; c0_if.psum_in = p;
    c0_if.w_in = w; c0_if.w_load = ld; c0_if.w_swap = sw;
  endtask

  task automatic drv_c3(input logic [DW-1:0] a, input logic av, input logic [CW-1:0] p);
    c3_if.act_in = a; c3_if.act_valid_in = av; c3_if.psum_in = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_m(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_checks++;
    if ({m_if.psum_out, m_if.psum_valid_out, m_if.act_out, m_if.act_valid_out,
         m_if.w_out, m_if.ovf} !== '0)
      $display("FAIL reset_outputs got psum=%h pv=%b act=%h av=%b w=%h ovf=%b exp all 0",
               m_if.psum_out, m_if.psum_valid_out, m_if.act_out, m_if.act_valid_out,
               m_if.w_out, m_if.ovf);
    else n_pass++;
    rst = 1'b0;
    drv_m(0, 16'd7, 1, 40'd100, 0, 0, 0);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'd100 || m_if.psum_valid_out !== 1'b1)
      $display("FAIL empty_passthru got %0d/%b exp 100/1", m_if.psum_out, m_if.psum_valid_out);
    else n_pass++;
    n_checks++;
    if (m_if.act_out !== 16'd7 || m_if.act_valid_out !== 1'b1)
      $display("FAIL act_forward got %0d/%b exp 7/1", m_if.act_out, m_if.act_valid_out);
    else n_pass++;
  endtask

  task automatic test_load();
    drv_m(0, 0, 0, 0, 16'd3, 1, 0);
    tick();
    n_checks++;
    if (m_if.w_out !== 16'd3) $display("FAIL load_shadow got %0d exp 3", m_if.w_out);
    else n_pass++;
    drv_m(0, 0, 0, 0, 0, 0, 1);
    tick();
    drv_m(0, 16'd5, 1, 40'd10, 0, 0, 0);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'd25 || m_if.psum_valid_out !== 1'b1)
      $display("FAIL load_compute got %0d/%b exp 25/1", m_if.psum_out, m_if.psum_valid_out);
    else n_pass++;
  endtask

  task automatic test_swap_hazard();
    drv_m(0, 0, 0, 0, 16'hFFFE, 1, 0);
    tick();
    drv_m(0, 16'd4, 1, 40'd0, 0, 0, 1);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'd12)
      $display("FAIL swap_uses_old got %0d exp 12", $signed(m_if.psum_out));
    else n_pass++;
    drv_m(0, 16'd4, 1, 40'd0, 0, 0, 0);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'(-8))
      $display("FAIL swap_new_eff got %0d exp -8", $signed(m_if.psum_out));
    else n_pass++;
  endtask

  task automatic test_clear_reset();
    // Active weight is -2 here.
    drv_m(1, 16'd4, 1, 40'd0, 0, 0, 0);
    tick();
    n_checks++;
    if ({m_if.psum_out, m_if.psum_valid_out, m_if.act_out, m_if.act_valid_out, m_if.ovf} !== '0)
      $display("FAIL clear_zero got psum=%h pv=%b act=%h av=%b ovf=%b exp all 0",
               m_if.psum_out, m_if.psum_valid_out, m_if.act_out, m_if.act_valid_out, m_if.ovf);
    else n_pass++;
    drv_m(0, 16'd3, 1, 40'd1, 0, 0, 0);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'(-5))
      $display("FAIL clear_keeps_w got %0d exp -5", $signed(m_if.psum_out));
    else n_pass++;
    drv_m(0, 16'd3, 1, 40'd1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_if.psum_valid_out !== 1'b0 || m_if.psum_out !== '0)
      $display("FAIL async_rst got %h/%b exp 0/0", m_if.psum_out, m_if.psum_valid_out);
    else n_pass++;
    tick();
    rst = 1'b0;
    drv_m(0, 16'd7, 1, 40'd100, 0, 0, 1);
    tick();
    drv_m(0, 16'd7, 1, 40'd100, 0, 0, 0);
    tick();
    n_checks++;
    if (m_if.psum_out !== 40'd100)
      $display("FAIL rst_empty got %0d exp 100", $signed(m_if.psum_out));
    else n_pass++;
  endtask

  task automatic test_chain();
    c1_if.clear = 0; c1_if.act_in = 0; c1_if.act_valid_in = 0; c1_if.psum_in = 0;
    c2_if.clear = 0; c2_if.act_in = 0; c2_if.act_valid_in = 0; c2_if.psum_in = 0;
    c3_if.clear = 0;
    drv_c3(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      drv_c0(0, 0, 0, 0, 16'(k), 1, 0);
      tick();
    end
    n_checks++;
    if (c3_if.w_out !== 16'd1 || c2_if.w_out !== 16'd2 || c1_if.w_out !== 16'd3 ||
        c0_if.w_out !== 16'd4)
      $display("FAIL chain_shadow got %0d,%0d,%0d,%0d exp 1,2,3,4", c3_if.w_out, c2_if.w_out,
               c1_if.w_out, c0_if.w_out);
    else n_pass++;
    drv_c0(0, 0, 0, 0, 16'd9, 1, 1);
    tick();
    n_checks++;
    if (c0_if.w_out !== 16'd9 || c3_if.w_out !== 16'd2)
      $display("FAIL ldswap_shadow got %0d,%0d exp 9,2", c0_if.w_out, c3_if.w_out);
    else n_pass++;
    drv_c0(0, 16'd1, 1, 0, 0, 0, 0);
    drv_c3(16'd1, 1, 0);
    tick();
    n_checks++;
    if (c0_if.psum_out !== 32'd4 || c3_if.psum_out !== 32'd1)
      $display("FAIL ldswap_active got %0d,%0d exp 4,1", c0_if.psum_out, c3_if.psum_out);
    else n_pass++;
    drv_c0(0, 16'd2, 1, 0, 0, 0, 1);
    drv_c3(0, 0, 0);
    tick();
    n_checks++;
    if (c0_if.psum_out !== 32'd8)
      $display("FAIL ldswap_vld_swap got %0d exp 8", c0_if.psum_out);
    else n_pass++;
    drv_c0(0, 16'd2, 1, 32'd1, 0, 0, 0);
    drv_c3(16'd2, 1, 32'd1);
    tick();
    n_checks++;
    if (c0_if.psum_out !== 32'd19 || c3_if.psum_out !== 32'd5)
      $display("FAIL ldswap_second got %0d,%0d exp 19,5", c0_if.psum_out, c3_if.psum_out);
    else n_pass++;
    drv_c0(0, 0, 0, 0, 0, 0, 1);
    drv_c3(0, 0, 0);
    tick();
    drv_c0(0, 16'd1, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (c0_if.psum_out !== 32'd9)
      $display("FAIL swap_ignored got %0d exp 9", c0_if.psum_out);
    else n_pass++;
  endtask

  task automatic test_overflow();
    drv_c0(0, 0, 0, 0, 16'h8000, 1, 0);
    tick();
    drv_c0(0, 0, 0, 0, 0, 0, 1);
    tick();
    drv_c0(0, 16'h8000, 1, 32'h7FFF_FFFF, 0, 0, 0);
    tick();
`ifdef PE_SATURATE_EN
    n_checks++;
    if (c0_if.psum_out !== 32'h7FFF_FFFF || c0_if.ovf !== 1'b1)
      $display("FAIL ovf_sat got %h/%b exp 7fffffff/1", c0_if.psum_out, c0_if.ovf);
    else n_pass++;
    drv_c0(0, 0, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (c0_if.ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", c0_if.ovf);
    else n_pass++;
`else
    n_checks++;
    if (c0_if.psum_out !== 32'hBFFF_FFFF || c0_if.ovf !== 1'b0)
      $display("FAIL ovf_wrap got %h/%b exp bfffffff/0", c0_if.psum_out, c0_if.ovf);
    else n_pass++;
`endif
    drv_c0(1, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (c0_if.ovf !== 1'b0 || c0_if.psum_out !== '0)
      $display("FAIL ovf_clear got %h/%b exp 0/0", c0_if.psum_out, c0_if.ovf);
    else n_pass++;
    drv_c0(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    longint active, shadow, psum, act, prod, sum, mx, mn;
    bit svld, loaded, pvld, avld, ovf, clamp, do_swap;
    logic clr, av, ld, sw;
    logic [DW-1:0] a, w;
    logic [AW-1:0] p;
    int bad;
    active = 0; shadow = 0; psum = 0; act = 0;
    svld = 0; loaded = 0; pvld = 0; avld = 0; ovf = 0;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -mx - 1;
    rst = 1'b1;
    drv_m(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 19) == 0);
      av  = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 3) == 0);
      sw  = ($urandom_range(0, 4) == 0);
      a   = 16'($urandom());
      w   = 16'($urandom());
      p   = 40'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) p = $urandom_range(0, 1) ? 40'h7F_FFFF_FFFF : 40'h80_0000_0000;
      // Reference: spec rules in plain integer arithmetic.
      prod = loaded ? sx(longint'(a), DW) * active : 0;
      sum  = sx(longint'(p), AW) + prod;
      clamp = 0;
`ifdef PE_SATURATE_EN
      if (sum > mx) begin sum = mx; clamp = 1; end
      else if (sum < mn) begin sum = mn; clamp = 1; end
`else
      sum = sx(sum, AW);
`endif
      if (clr) begin
        psum = 0; pvld = 0; act = 0; avld = 0; ovf = 0;
      end else begin
        act = longint'(a); avld = av; pvld = av;
        if (av) begin psum = sum; ovf = ovf | clamp; end
      end
      do_swap = sw && svld;
      if (do_swap) begin active = shadow; loaded = 1; end
      if (ld) begin shadow = sx(longint'(w), DW); svld = 1; end
      else if (do_swap) svld = 0;
      drv_m(clr, a, av, p, w, ld, sw);
      tick();
      bad = 0;
      n_checks++;
      if (m_if.psum_out !== 40'(psum) || m_if.psum_valid_out !== pvld) begin
        $display("FAIL rand_psum cyc %0d got %h/%b exp %h/%b", i, m_if.psum_out,
                 m_if.psum_valid_out, 40'(psum), pvld);
        bad = 1;
      end else n_pass++;
      n_checks++;
      if (m_if.act_out !== 16'(act) || m_if.act_valid_out !== avld ||
          m_if.w_out !== 16'(shadow) || m_if.ovf !== ovf)
        $display("FAIL rand_side cyc %0d got act=%h av=%b w=%h ovf=%b exp %h %b %h %b", i,
                 m_if.act_out, m_if.act_valid_out, m_if.w_out, m_if.ovf, 16'(act), avld,
                 16'(shadow), ovf);
      else n_pass++;
      if (bad != 0) begin
        // Resync the model so one fault does not flood the log.
        psum = sx(longint'(m_if.psum_out), AW);
      end
    end
  endtask

  initial begin
    drv_m(0, 0, 0, 0, 0, 0, 0);
    drv_c0(0, 0, 0, 0, 0, 0, 0);
    c1_if.clear = 0; c1_if.act_in = 0; c1_if.act_valid_in = 0; c1_if.psum_in = 0;
    c2_if.clear = 0; c2_if.act_in = 0; c2_if.act_valid_in = 0; c2_if.psum_in = 0;
    c3_if.clear = 0;
    drv_c3(0, 0, 0);
    test_reset();
    test_load();
    test_swap_hazard();
    test_clear_reset();
    test_chain();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
